// File: rtl/io_mmio_ctrl_if.sv
// Memory-stage I/O bus: load/store request, registered read data, retire
// strobe and the UART TX/RX handshakes that this controller owns.
interface io_mmio_ctrl_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic        re;
   logic        inst_retire;
   logic [31:0] io_dout;
   logic [7:0]  uart_tx_data_in;
   logic        uart_tx_data_in_valid;
   logic        uart_tx_data_in_ready;
   logic [7:0]  uart_rx_data_out;
   logic        uart_rx_data_out_valid;
   logic        uart_rx_data_out_ready;

   // Core + UART side: drives requests and UART status, observes results.
   modport master (
      output addr, wdata, we, re, inst_retire,
      output uart_tx_data_in_ready, uart_rx_data_out, uart_rx_data_out_valid,
      input  io_dout, uart_tx_data_in, uart_tx_data_in_valid, uart_rx_data_out_ready
   );

   // Controller side.
   modport slave (
      input  addr, wdata, we, re, inst_retire,
      input  uart_tx_data_in_ready, uart_rx_data_out, uart_rx_data_out_valid,
      output io_dout, uart_tx_data_in, uart_tx_data_in_valid, uart_rx_data_out_ready
   );
endinterface

// File: rtl/io_mmio_ctrl.sv
// MMIO controller: decodes the I/O region, buffers one TX byte, pops RX
// bytes on data-register loads and keeps the cycle/instruction counters.
module io_mmio_ctrl #(
   parameter logic [3:0] IO_REGION = 4'b1000,
   parameter int         CNT_WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst,
   io_mmio_ctrl_if.slave bus
);
   localparam logic [7:0] OFF_STATUS = 8'h00;
   localparam logic [7:0] OFF_RXDATA = 8'h04;
   localparam logic [7:0] OFF_TXDATA = 8'h08;
   localparam logic [7:0] OFF_CYCLE  = 8'h10;
   localparam logic [7:0] OFF_INST   = 8'h14;
   localparam logic [7:0] OFF_CNTRST = 8'h18;

   logic [31:0]          r_io_dout;
   logic [7:0]           r_tx_buf;
   logic                 r_tx_full;
   logic [CNT_WIDTH-1:0] r_cycle_cnt;
   logic [CNT_WIDTH-1:0] r_inst_cnt;

   logic        w_hit;
   logic [7:0]  w_off;
   logic        w_rd;
   logic        w_wr;
   logic        w_tx_fire;
   logic        w_tx_wr;
   logic        w_cnt_clr;
   logic [31:0] w_rdata;
   logic        w_unused;

   assign w_hit     = (bus.addr[31:28] == IO_REGION);
   assign w_off     = bus.addr[7:0];
   assign w_rd      = bus.re & w_hit;
   assign w_wr      = bus.we & w_hit;
   assign w_tx_fire = r_tx_full & bus.uart_tx_data_in_ready;
   assign w_tx_wr   = w_wr & (w_off == OFF_TXDATA);
   assign w_cnt_clr = w_wr & (w_off == OFF_CNTRST);

   // Address bits between the region nibble and the offset byte are don't-care.
   assign w_unused = ^{bus.addr[27:8], bus.wdata[31:8]};

   // RX pop is purely combinational and deliberately not gated by reset.
   assign bus.uart_rx_data_out_ready = w_rd & (w_off == OFF_RXDATA);
   assign bus.uart_tx_data_in        = r_tx_buf;
   assign bus.uart_tx_data_in_valid  = r_tx_full;
   assign bus.io_dout                = r_io_dout;

   // Read mux; counters are sampled pre-edge and zero-extended to 32 bits.
   always_comb begin
      w_rdata = 32'h0;
      case (w_off)
         OFF_STATUS: w_rdata = {30'b0, bus.uart_rx_data_out_valid, ~r_tx_full};
         OFF_RXDATA: w_rdata = {24'b0, bus.uart_rx_data_out};
         OFF_CYCLE:  w_rdata = 32'(r_cycle_cnt);
         OFF_INST:   w_rdata = 32'(r_inst_cnt);
         default:    w_rdata = 32'h0;
      endcase
   end

   // Registered read data: updates only on a hitting load, otherwise holds.
   always_ff @(posedge clk) begin
      if (rst)       r_io_dout <= 32'h0;
      else if (w_rd) r_io_dout <= w_rdata;
   end

   // One-entry TX buffer; a store may refill it in the same cycle it drains.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_buf  <= 8'h0;
         r_tx_full <= 1'b0;
      end else if (w_tx_wr && (!r_tx_full || w_tx_fire)) begin
         r_tx_buf  <= bus.wdata[7:0];
         r_tx_full <= 1'b1;
      end else if (w_tx_fire) begin
         r_tx_full <= 1'b0;
      end
   end

   // Free-running counters; a counter-reset store wins over the increment.
   always_ff @(posedge clk) begin
      if (rst || w_cnt_clr) begin
         r_cycle_cnt <= '0;
         r_inst_cnt  <= '0;
      end else begin
         r_cycle_cnt <= r_cycle_cnt + CNT_WIDTH'(1);
         r_inst_cnt  <= r_inst_cnt + CNT_WIDTH'(bus.inst_retire);
      end
   end
endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Bench for io_mmio_ctrl: directed test-plan sequences followed by random
// traffic, all checked against a cycle-level behavioural model. A second
// instance with 4-bit counters exercises counter wrap-around.
module tb_io_mmio_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   io_mmio_ctrl_if bus ();
   io_mmio_ctrl_if bus2 ();

   io_mmio_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));
   io_mmio_ctrl #(.CNT_WIDTH(4)) dut_w (.clk(clk), .rst(rst), .bus(bus2.slave));

   // Narrow instance continuously reads its cycle counter.
   initial begin
      bus2.addr = 32'h8000_0010; bus2.wdata = 32'h0; bus2.we = 1'b0; bus2.re = 1'b1;
      bus2.inst_retire = 1'b0; bus2.uart_tx_data_in_ready = 1'b0;
      bus2.uart_rx_data_out = 8'h0; bus2.uart_rx_data_out_valid = 1'b0;
   end

   int checks = 0;
   int failures = 0;

   // Reference model state
   int unsigned m_cyc, m_ins, m_cyc2;
   logic [31:0] m_dout, m_dout2;
   logic [7:0]  m_tx_buf;
   bit          m_tx_full;
   int          m_sent;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h @%0t", tag, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] d, input bit w, input bit r,
                        input bit ret, input bit txr, input bit rxv, input logic [7:0] rxd);
      bus.addr = a; bus.wdata = d; bus.we = w; bus.re = r; bus.inst_retire = ret;
      bus.uart_tx_data_in_ready = txr; bus.uart_rx_data_out_valid = rxv;
      bus.uart_rx_data_out = rxd;
   endtask

   // One clock: check combinational outputs, advance the model, then check
   // registered outputs just after the edge.
   task automatic step();
      bit         hit, rd, wr, fire;
      logic [7:0] off;
      #1;
      hit = (bus.addr[31:28] == 4'h8);
      off = bus.addr[7:0];
      rd  = bus.re && hit;
      wr  = bus.we && hit;
      chk("rx_ready", {31'b0, bus.uart_rx_data_out_ready}, {31'b0, rd && off == 8'h04});
      chk("tx_valid", {31'b0, bus.uart_tx_data_in_valid}, {31'b0, m_tx_full});
      if (m_tx_full) chk("tx_data", {24'b0, bus.uart_tx_data_in}, {24'b0, m_tx_buf});
      if (rst) begin
         m_dout = 0; m_tx_buf = 0; m_tx_full = 0; m_cyc = 0; m_ins = 0;
         m_dout2 = 0; m_cyc2 = 0;
      end else begin
         if (rd) begin
            case (off)
               8'h00:   m_dout = {30'b0, bus.uart_rx_data_out_valid, !m_tx_full};
               8'h04:   m_dout = {24'b0, bus.uart_rx_data_out};
               8'h10:   m_dout = m_cyc;
               8'h14:   m_dout = m_ins;
               default: m_dout = 0;
            endcase
         end
         fire = m_tx_full && bus.uart_tx_data_in_ready;
         if (fire) m_sent++;
         if (wr && off == 8'h08) begin
            if (!m_tx_full || fire) begin
               m_tx_buf = bus.wdata[7:0];
               m_tx_full = 1;
            end
         end else if (fire) m_tx_full = 0;
         if (wr && off == 8'h18) begin
            m_cyc = 0; m_ins = 0;
         end else begin
            m_cyc++;
            if (bus.inst_retire) m_ins++;
         end
         m_dout2 = m_cyc2 % 16;
         m_cyc2++;
      end
      @(posedge clk);
      #1;
      chk("io_dout", bus.io_dout, m_dout);
      chk("io_dout_w", bus2.io_dout, m_dout2);
   endtask

   task automatic idle(input int n, input bit txr);
      for (int i = 0; i < n; i++) begin
         drive(32'h0, 32'h0, 0, 0, 0, txr, 0, 8'h0);
         step();
      end
   endtask

   initial begin
      logic [31:0] offs [8];
      logic [31:0] a;
      int          sent0;
      offs[0] = 32'h00; offs[1] = 32'h04; offs[2] = 32'h08; offs[3] = 32'h10;
      offs[4] = 32'h14; offs[5] = 32'h18; offs[6] = 32'h0C; offs[7] = 32'hFC;
      m_sent = 0;

      // Reset
      rst = 1'b1;
      idle(2, 0);
      chk("rst_dout", bus.io_dout, 32'h0);
      chk("rst_tx_valid", {31'b0, bus.uart_tx_data_in_valid}, 32'h0);
      rst = 1'b0;

      // Status after reset: tx_ready=1, rx_valid=0
      drive(32'h8000_0000, 0, 0, 1, 0, 0, 0, 8'h0); step();
      chk("status_idle", bus.io_dout, 32'h1);

      // Store 0x41 with TX not ready for several cycles
      drive(32'h8000_0008, 32'h41, 1, 0, 0, 0, 0, 8'h0); step();
      idle(3, 0);
      chk("tx_hold_data", {24'b0, bus.uart_tx_data_in}, 32'h41);
      // Second store while full and not ready: dropped
      drive(32'h8000_0008, 32'h42, 1, 0, 0, 0, 0, 8'h0); step();
      chk("tx_drop", {24'b0, bus.uart_tx_data_in}, 32'h41);
      sent0 = m_sent;
      idle(1, 1);
      chk("one_handshake", m_sent - sent0, 1);
      drive(32'h8000_0000, 0, 0, 1, 0, 0, 0, 8'h0); step();
      chk("status_after_tx", bus.io_dout, 32'h1);

      // Refill in the same cycle as the handshake
      drive(32'h8000_0008, 32'h41, 1, 0, 0, 0, 0, 8'h0); step();
      drive(32'h8000_0008, 32'h42, 1, 0, 0, 1, 0, 8'h0); step();
      chk("tx_refill_valid", {31'b0, bus.uart_tx_data_in_valid}, 32'h1);
      chk("tx_refill_data", {24'b0, bus.uart_tx_data_in}, 32'h42);
      idle(1, 1);

      // RX pops
      drive(32'h8000_0004, 0, 0, 1, 0, 0, 1, 8'h5A); step();
      chk("rx_read", bus.io_dout, 32'h5A);
      drive(32'h8000_0004, 0, 0, 1, 0, 0, 0, 8'h5A); step();
      chk("rx_read_empty", bus.io_dout, 32'h5A);

      // Counters from reset: 10 cycles, 4 retires
      rst = 1'b1; idle(1, 0); rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive(32'h0, 0, 0, 0, (i < 4), 0, 0, 8'h0); step();
      end
      drive(32'h8000_0010, 0, 0, 1, 0, 0, 0, 8'h0); step();
      chk("cycle_cnt10", bus.io_dout, 32'd10);
      drive(32'h8000_0014, 0, 0, 1, 0, 0, 0, 8'h0); step();
      chk("inst_cnt4", bus.io_dout, 32'd4);
      drive(32'h8000_0018, 32'hDEAD, 1, 0, 1, 0, 0, 8'h0); step();
      drive(32'h8000_0010, 0, 0, 1, 0, 0, 0, 8'h0); step();
      chk("cycle_clr", bus.io_dout, 32'd0);
      drive(32'h8000_0014, 0, 0, 1, 1, 0, 0, 8'h0); step();
      chk("inst_clr", bus.io_dout, 32'd0);

      // Out-of-region load: no update, no RX pop
      drive(32'h0000_1004, 0, 0, 1, 0, 0, 1, 8'h77); step();
      chk("miss_hold", bus.io_dout, 32'd0);

      // Reset while a byte is pending
      drive(32'h8000_0008, 32'h99, 1, 0, 0, 0, 0, 8'h0); step();
      rst = 1'b1; idle(1, 0); rst = 1'b0;
      chk("rst_pending_valid", {31'b0, bus.uart_tx_data_in_valid}, 32'h0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         a = offs[$urandom_range(7)];
         if ($urandom_range(9) == 0) a = a | 32'h0000_1000;
         else a = a | 32'h8000_0000 | ($urandom_range(1) ? 32'h0ABC_DE00 : 32'h0);
         drive(a, $urandom, ($urandom_range(2) == 0), $urandom_range(1),
               $urandom_range(1), $urandom_range(1), $urandom_range(1), 8'($urandom));
         rst = ($urandom_range(60) == 0);
         step();
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
